// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption core: one inverse round per clock, round keys fetched by index.
// Optional abort port and early-exit behaviour enabled with `define AES_INV_ABORT_EN.

module inv_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_b
);

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // entry i lives at bits [8*(255-i)+7 -: 8], and 8*(255-i)+7 == {~i, 3'b111}
  assign o_b = INV_SBOX[{~i_a, 3'b111} -: 8];

endmodule

module aes_inv_cipher (
  input  logic         clk,
  input  logic         rst,
`ifdef AES_INV_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  fsm_t         r_fsm;
  fsm_t         w_fsm_run;
  fsm_t         w_fsm_nxt;
  logic [127:0] r_state;
  logic [3:0]   r_round;
  logic [127:0] r_out_data;
  logic [127:0] w_shift;
  logic [127:0] w_sub;
  logic [127:0] w_ark;
  logic [127:0] w_mix;
  logic         w_abort;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    logic [7:0] acc;
    x2  = xtime(b);
    x4  = xtime(x2);
    x8  = xtime(x4);
    acc = 8'h00;
    if (c[0]) acc = acc ^ b;
    if (c[1]) acc = acc ^ x2;
    if (c[2]) acc = acc ^ x4;
    if (c[3]) acc = acc ^ x8;
    return acc;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [31:0] res;
    for (int r = 0; r < 4; r++) a[r] = c[31-8*r -: 8];
    res = 32'h0;
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = gmul(a[r], 4'he) ^ gmul(a[(r+1)%4], 4'hb) ^
                         gmul(a[(r+2)%4], 4'hd) ^ gmul(a[(r+3)%4], 4'h9);
    end
    return res;
  endfunction

`ifdef AES_INV_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // InvShiftRows is pure wiring: row r of column c comes from column (c - r) mod 4
  for (genvar g = 0; g < 16; g++) begin : g_byte
    localparam int SRC = 4 * (((g / 4) - (g % 4) + 4) % 4) + (g % 4);
    assign w_shift[127-8*g -: 8] = r_state[127-8*SRC -: 8];
    inv_sbox u_inv_sbox (
      .i_a (w_shift[127-8*g -: 8]),
      .o_b (w_sub[127-8*g -: 8])
    );
  end

  assign w_ark = w_sub ^ rk;

  always_comb begin
    w_mix = 128'h0;
    for (int c = 0; c < 4; c++) begin
      w_mix[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
    end
  end

  always_comb begin
    w_fsm_run = r_fsm;
    case (r_fsm)
      IDLE:    w_fsm_run = in_valid ? ROUND : IDLE;
      ROUND:   w_fsm_run = (r_round == 4'd1) ? FINAL : ROUND;
      FINAL:   w_fsm_run = DONE;
      DONE:    w_fsm_run = out_ready ? IDLE : DONE;
      default: w_fsm_run = IDLE;
    endcase
  end

  // abort outranks the output handshake and is meaningless while idle
  assign w_fsm_nxt = (w_abort && (r_fsm != IDLE)) ? IDLE : w_fsm_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= 128'h0;
      r_round    <= 4'd0;
      r_out_data <= 128'h0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_state <= in_data ^ rk;
            r_round <= 4'd9;
          end
        end
        ROUND: begin
          r_state <= w_mix;
          r_round <= r_round - 4'd1;
        end
        FINAL: begin
          r_state <= w_ark;
          if (!w_abort) begin
            r_out_data <= w_ark;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_fsm == IDLE);
    out_valid = (r_fsm == DONE);
    out_data  = r_out_data;
    case (r_fsm)
      IDLE:    rk_idx = 4'd10;
      ROUND:   rk_idx = r_round;
      FINAL:   rk_idx = 4'd0;
      DONE:    rk_idx = 4'd10;
      default: rk_idx = 4'd10;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Scoreboard bench for aes_inv_cipher using FIPS-197 App. B and App. C.1 vectors;
// exercises the abort path when AES_INV_ABORT_EN is defined.

module tb_aes_inv_cipher;

  localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;

  localparam logic [127:0] KS_C [0:10] = '{
    128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5};
  localparam logic [127:0] KS_B [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

  typedef struct {
    logic [127:0] pt;
    int           t_acc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef AES_INV_ABORT_EN
  logic         abort;
`endif

  logic in_key;
  logic busy_key;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];
  int   out_cycles[$];

  aes_inv_cipher dut (
    .clk       (clk),
    .rst       (rst),
`ifdef AES_INV_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  function automatic logic [127:0] get_rk(input logic kb, input logic [3:0] idx);
    if (idx > 4'd10) return 128'h0;
    return kb ? KS_B[idx] : KS_C[idx];
  endfunction

  // key-expansion store model: pending block's key while idle, in-flight block's key otherwise
  assign rk = get_rk(in_ready ? in_key : busy_key, rk_idx);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc      = 0;
    busy_key = 1'b0;
    forever begin
      @(posedge clk);
      if (in_valid && in_ready && !rst) busy_key = in_key;
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: cycle bound expired", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: latency on the rising edge of out_valid, data on the handshake
  initial begin
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (sb.size() == 0) bound_fail("unexpected_out_valid");
          else check("latency", 128'(cyc - sb[0].t_acc), 128'd11);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            bound_fail("unexpected_output");
          end else begin
            check("out_data", out_data, sb[0].pt);
            void'(sb.pop_front());
            out_cycles.push_back(cyc);
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  // Wait (bounded) for the block held on in_data to be accepted, then record its expectation
  task automatic wait_accept(input logic [127:0] pt, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready && in_valid && !rst) begin
        ok = 1'b1;
        sb.push_back('{pt: pt, t_acc: cyc});
      end
    end
    if (!ok) bound_fail(name);
    tick(1);
  endtask

  task automatic send(input logic [127:0] ct, input logic kb, input logic [127:0] pt);
    in_data  = ct;
    in_key   = kb;
    in_valid = 1'b1;
    wait_accept(pt, "accept_timeout");
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) bound_fail(name);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 128'h0;
    in_key    = 1'b0;
    out_ready = 1'b1;
`ifdef AES_INV_ABORT_EN
    abort     = 1'b0;
`endif
    tick(3);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'h0);
    check("rst_rk_idx", 128'(rk_idx), 128'd10);
    rst = 1'b0;
    tick(2);

    // App. C.1
    send(CT_C, 1'b0, PT_C);
    wait_drain("drain_c1");
    tick(1);

    // App. B with round-key index sequence
    check("idle_rk_idx", 128'(rk_idx), 128'd10);
    send(CT_B, 1'b1, PT_B);
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      check("rk_idx_seq", 128'(rk_idx), 128'(i));
    end
    wait_drain("drain_b");
    tick(1);

    // Backpressure in DONE with junk on in_data
    out_ready = 1'b0;
    send(CT_C, 1'b0, PT_C);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        @(negedge clk);
        seen = out_valid;
      end
      if (!seen) bound_fail("bp_out_valid");
    end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_out_data", out_data, PT_C);
      check("bp_in_ready", 128'(in_ready), 128'd0);
    end
    tick(1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(1);
    @(negedge clk);
    check("release_in_ready", 128'(in_ready), 128'd1);
    check("release_out_valid", 128'(out_valid), 128'd0);
    check("release_out_data_hold", out_data, PT_C);
    check("bp_sb_empty", 128'(sb.size()), 128'd0);
    tick(1);

    // Back-to-back with in_valid held high
    out_cycles.delete();
    in_valid = 1'b1;
    in_data  = CT_C;
    in_key   = 1'b0;
    wait_accept(PT_C, "b2b_accept1");
    in_data = CT_B;
    in_key  = 1'b1;
    wait_accept(PT_B, "b2b_accept2");
    in_valid = 1'b0;
    wait_drain("drain_b2b");
    if (out_cycles.size() == 2) check("b2b_interval", 128'(out_cycles[1] - out_cycles[0]), 128'd12);
    else bound_fail("b2b_two_outputs");
    tick(1);

    // Reset in the middle of a block
    send(CT_C, 1'b0, PT_C);
    tick(4);
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_out_data", out_data, 128'h0);
    tick(2);
    rst = 1'b0;
    tick(15);
    send(CT_B, 1'b1, PT_B);
    wait_drain("drain_after_rst");
    tick(1);

`ifdef AES_INV_ABORT_EN
    send(CT_C, 1'b0, PT_C);
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_in_ready", 128'(in_ready), 128'd1);
    check("abort_out_valid", 128'(out_valid), 128'd0);
    tick(15);
    send(CT_B, 1'b1, PT_B);
    wait_drain("drain_after_abort");
    tick(1);
`endif

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher.md
# aes_inv_cipher

Iterative AES-128 decryption core that turns a 128-bit ciphertext block into plaintext, one round per clock. It is the decrypt-side counterpart of the encryption datapath: it applies InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns, with round keys fetched by index from an external key-expansion store. It sits between the ciphertext source and the plaintext sink and uses valid/ready handshakes on both sides.

## Interface
- No parameters. Key size fixed at 128 bits, Nr = 10.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  ciphertext on in_data is valid.
- in_ready  out  1  core can accept a block; high only in IDLE.
- in_data  in  128  ciphertext; byte k = in_data[127-8k -: 8], FIPS-197 column-major (k = 4*col + row).
- rk_idx  out  4  round-key index requested this cycle (0..10).
- rk  in  128  round key for rk_idx; must be valid combinationally in the same cycle; same byte order as in_data.
- out_valid  out  1  plaintext on out_data is valid.
- out_ready  in  1  sink accepts out_data.
- out_data  out  128  plaintext, same byte order.
- abort  in  1  present only with AES_INV_ABORT_EN.

## Operation
- Datapath: 128-bit state register and 4-bit round counter.
- InvSubBytes uses 16 instances of the team's combinational inv_sbox block (8-bit in, 8-bit out).
- InvMixColumns per column: GF(2^8) with polynomial 0x11B; out_r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3), with row indices taken mod 4.
- InvShiftRows: row r rotates right by r. Output byte k takes input byte {0,13,10,7, 4,1,14,11, 8,5,2,15, 12,9,6,3}[k].
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE: rk_idx=10. On in_valid && in_ready, state <= in_data ^ rk, round <= 9, go to ROUND.
- ROUND: rk_idx=round. state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk). round decrements. After round 1 is applied, go to FINAL.
- FINAL: rk_idx=0. state <= InvSubBytes(InvShiftRows(state)) ^ rk. Go to DONE.
- DONE: out_valid=1 and out_data=state, held stable while out_ready=0. On out_ready go to IDLE.
- in_data is ignored outside IDLE. out_data holds the last result after handshake until the next FINAL.
- rst mid-operation: the block is discarded, the FSM returns to IDLE, and no output is produced.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, rk_idx=10, FSM=IDLE, round=0.
- Block accepted at the edge ending cycle T.
- ROUND occupies cycles T+1..T+9 (rk_idx 9..1).
- FINAL is cycle T+10 (rk_idx 0).
- out_valid first high in cycle T+11. Latency is 11 cycles.
- in_ready is low from T+1 until the cycle after the out handshake.
- Minimum block interval is 12 cycles when out_ready is held high.
- in_ready and out_valid are decoded from the FSM register only, with no combinational path from inputs.
- rk_idx is decoded from FSM/round registers only.

## Configuration
- AES_INV_ABORT_EN defined:
  - Adds the abort port.
  - abort=1 in ROUND, FINAL or DONE forces IDLE at the next edge. out_valid drops and the result is discarded.
  - abort in IDLE has no effect.
  - abort has priority over the out handshake in the same cycle.
- AES_INV_ABORT_EN undefined: no abort port; the FSM runs every accepted block to completion.

## Test plan
- FIPS-197 App. C.1 (key 000102030405060708090a0b0c0d0e0f, bench supplies expanded keys by rk_idx). ct 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid exactly 11 cycles after acceptance.
- FIPS-197 App. B (key 2b7e151628aed2a6abf7158809cf4f3c). ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734. Check rk_idx sequence 10,9,…,1,0.
- Backpressure: out_ready low for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, and a changing in_data is ignored. Release -> in_ready=1 next cycle.
- Back-to-back: the App. C.1 and App. B ciphertexts offered with in_valid held high and out_ready=1 -> two correct results, 12 cycles apart.
- rst asserted at cycle T+5 of a block -> immediately in_ready=1, out_valid=0, out_data=0. No result is emitted, and the next block decrypts correctly.
- With AES_INV_ABORT_EN: abort at T+4 -> IDLE at T+5, no out_valid. A following App. B block gives the correct plaintext.
